// File: rtl/mul_pkg.sv
// mul_pkg: shared types and helpers for the pipelined multiply unit.
//   mul_op_t        : RISC-V M-extension multiply flavour (MUL/MULH/MULHSU/MULHU).
//   rows_per_stage  : partial-product rows handled by each compute stage.
//   is_signed_a/b   : whether rs1/rs2 are interpreted as signed for an op.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULH   = 2'd1,
    MUL_OP_MULHSU = 2'd2,
    MUL_OP_MULHU  = 2'd3
  } mul_op_t;

  function automatic int rows_per_stage(input int data_width, input int depth);
    return data_width / depth;
  endfunction

  function automatic logic is_signed_a(input mul_op_t op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  function automatic logic is_signed_b(input mul_op_t op);
    return op == MUL_OP_MULH;
  endfunction

endpackage

// File: rtl/pipelined_mul_stage.sv
// pipelined_mul_stage: combinational shift-add block covering ROWS rows of
// the unsigned magnitude product.
//   mcand_i  : multiplicand magnitude
//   mplier_i : the multiplier bits consumed by this stage (LSB first)
//   sum_i    : previous stage row sum (bit 0 already retired as a finished bit)
//   carry_i  : previous stage row carry-out
//   sum_o    : last row sum of this stage
//   carry_o  : last row carry-out of this stage
//   fin_o    : product bits retired by this stage, LSB first
// The running high accumulator between rows is {carry, sum[W-1:1]}, i.e. the
// row sum shifted right by one; the dropped LSB is the finished product bit.
module pipelined_mul_stage
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 8
) (
  input  logic [DATA_WIDTH-1:0] mcand_i,
  input  logic [ROWS-1:0]       mplier_i,
  input  logic [DATA_WIDTH-1:0] sum_i,
  input  logic                  carry_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  carry_o,
  output logic [ROWS-1:0]       fin_o
);

  logic unused_sum_lsb;
  assign unused_sum_lsb = sum_i[0];

  always_comb begin
    logic [DATA_WIDTH:0]   acc;
    logic [DATA_WIDTH:0]   s;
    logic [DATA_WIDTH-1:0] pp;
    acc   = {1'b0, carry_i, sum_i[DATA_WIDTH-1:1]};
    s     = '0;
    pp    = '0;
    fin_o = '0;
    for (int r = 0; r < ROWS; r++) begin
      pp       = mplier_i[r] ? mcand_i : {DATA_WIDTH{1'b0}};
      s        = acc + {1'b0, pp};
      fin_o[r] = s[0];
      acc      = {1'b0, s[DATA_WIDTH:1]};
    end
    sum_o   = s[DATA_WIDTH-1:0];
    carry_o = s[DATA_WIDTH];
  end

endmodule

// File: rtl/pipelined_mul_unit.sv
// pipelined_mul_unit: PIPELINE_DEPTH-stage long multiplier for MUL/MULH/
// MULHSU/MULHU with valid/ready backpressure, flush and a passthrough tag.
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   flush_i               : kill all in-flight operations at the next edge
//   valid_i / ready_o     : input handshake
//   op_i, operand_a_i/b_i : operation and operands (rs1, rs2)
//   tag_i / tag_o         : opaque tag travelling with each operation
//   result_o, valid_o     : selected product half and its valid
//   ready_i               : downstream accepts the result
// Build option: define MUL_OUTPUT_REG_EN to register the negate/half-select
// result (latency PIPELINE_DEPTH+1); otherwise it is combinational after the
// last compute stage (latency PIPELINE_DEPTH).
//
// Handshake: an input transfers on an edge where valid_i & ready_o; a result
// transfers where valid_o & ready_i. A held result (valid_o & !ready_i)
// freezes every register, bubbles included, and drops ready_o. flush_i wins
// over the stall and drops any input offered in the same cycle.
module pipelined_mul_unit
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int PIPELINE_DEPTH = 4,
  parameter int TAG_WIDTH      = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  mul_op_t               op_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int W = DATA_WIDTH;
  localparam int D = PIPELINE_DEPTH;
  localparam int ROWS_PER_STAGE = rows_per_stage(DATA_WIDTH, PIPELINE_DEPTH);

  logic stall;
  logic advance;
  assign advance = ~stall;
  assign ready_o = ~stall;

  // Stage 0 sign handling: magnitudes are W-bit unsigned, so the most
  // negative operand maps to 2^(W-1) without overflow.
  logic          a_neg, b_neg;
  logic [W-1:0]  mag_a, mag_b;
  assign a_neg = is_signed_a(op_i) & operand_a_i[W-1];
  assign b_neg = is_signed_b(op_i) & operand_b_i[W-1];
  assign mag_a = a_neg ? -operand_a_i : operand_a_i;
  assign mag_b = b_neg ? -operand_b_i : operand_b_i;

  // Per-stage registers. mplier_q is pre-shifted so the next stage always
  // consumes its low bits; lo_q is the finished-bit delay chain, filled from
  // the top so the low product half is aligned after the last stage.
  logic                 vld_q   [D];
  mul_op_t              op_q    [D];
  logic                 neg_q   [D];
  logic [TAG_WIDTH-1:0] tag_q   [D];
  logic [W-1:0]         mcand_q [D];
  logic [W-1:0]         mplier_q[D];
  logic [W-1:0]         sum_q   [D];
  logic                 carry_q [D];
  logic [W-1:0]         lo_q    [D];

  logic                 in_vld   [D];
  mul_op_t              in_op    [D];
  logic                 in_neg   [D];
  logic [TAG_WIDTH-1:0] in_tag   [D];
  logic [W-1:0]         in_mcand [D];
  logic [W-1:0]         in_mplier[D];
  logic [W-1:0]         in_sum   [D];
  logic                 in_carry [D];
  logic [W-1:0]         in_lo    [D];

  logic [W-1:0]              st_sum  [D];
  logic                      st_carry[D];
  logic [ROWS_PER_STAGE-1:0] st_fin  [D];

  always_comb begin
    in_vld[0]    = valid_i;
    in_op[0]     = op_i;
    in_neg[0]    = a_neg ^ b_neg;
    in_tag[0]    = tag_i;
    in_mcand[0]  = mag_a;
    in_mplier[0] = mag_b;
    in_sum[0]    = '0;
    in_carry[0]  = 1'b0;
    in_lo[0]     = '0;
    for (int k = 1; k < D; k++) begin
      in_vld[k]    = vld_q[k-1];
      in_op[k]     = op_q[k-1];
      in_neg[k]    = neg_q[k-1];
      in_tag[k]    = tag_q[k-1];
      in_mcand[k]  = mcand_q[k-1];
      in_mplier[k] = mplier_q[k-1];
      in_sum[k]    = sum_q[k-1];
      in_carry[k]  = carry_q[k-1];
      in_lo[k]     = lo_q[k-1];
    end
  end

  for (genvar k = 0; k < D; k++) begin : g_stage
    pipelined_mul_stage #(
      .DATA_WIDTH (W),
      .ROWS       (ROWS_PER_STAGE)
    ) u_stage (
      .mcand_i  (in_mcand[k]),
      .mplier_i (in_mplier[k][ROWS_PER_STAGE-1:0]),
      .sum_i    (in_sum[k]),
      .carry_i  (in_carry[k]),
      .sum_o    (st_sum[k]),
      .carry_o  (st_carry[k]),
      .fin_o    (st_fin[k])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < D; k++) begin
        vld_q[k]    <= 1'b0;
        op_q[k]     <= MUL_OP_MUL;
        neg_q[k]    <= 1'b0;
        tag_q[k]    <= '0;
        mcand_q[k]  <= '0;
        mplier_q[k] <= '0;
        sum_q[k]    <= '0;
        carry_q[k]  <= 1'b0;
        lo_q[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < D; k++) begin
        if (flush_i) begin
          vld_q[k] <= 1'b0;
        end else if (advance) begin
          vld_q[k] <= in_vld[k];
        end
        if (advance) begin
          op_q[k]     <= in_op[k];
          neg_q[k]    <= in_neg[k];
          tag_q[k]    <= in_tag[k];
          mcand_q[k]  <= in_mcand[k];
          mplier_q[k] <= in_mplier[k] >> ROWS_PER_STAGE;
          sum_q[k]    <= st_sum[k];
          carry_q[k]  <= st_carry[k];
          lo_q[k]     <= W'({st_fin[k], in_lo[k]} >> ROWS_PER_STAGE);
        end
      end
    end
  end

  // Last stage: reassemble the magnitude, apply the sign, pick the half.
  // Negating zero yields zero modulo 2^(2W), so 0 * negative stays 0.
  logic [2*W-1:0] prod_mag, prod;
  logic [W-1:0]   res_sel;
  assign prod_mag = {carry_q[D-1], sum_q[D-1][W-1:1], lo_q[D-1]};
  assign prod     = neg_q[D-1] ? -prod_mag : prod_mag;
  assign res_sel  = (op_q[D-1] == MUL_OP_MUL) ? prod[W-1:0] : prod[2*W-1:W];

  logic unused_tail;
  assign unused_tail = ^{mcand_q[D-1], mplier_q[D-1], sum_q[D-1][0]};

`ifdef MUL_OUTPUT_REG_EN
  logic                 out_vld_q;
  logic [W-1:0]         out_res_q;
  logic [TAG_WIDTH-1:0] out_tag_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_vld_q <= 1'b0;
      out_res_q <= '0;
      out_tag_q <= '0;
    end else begin
      if (flush_i) begin
        out_vld_q <= 1'b0;
      end else if (advance) begin
        out_vld_q <= vld_q[D-1];
      end
      if (advance) begin
        out_res_q <= res_sel;
        out_tag_q <= tag_q[D-1];
      end
    end
  end

  assign stall    = out_vld_q & ~ready_i;
  assign valid_o  = out_vld_q;
  assign result_o = out_res_q;
  assign tag_o    = out_tag_q;
`else
  assign stall    = vld_q[D-1] & ~ready_i;
  assign valid_o  = vld_q[D-1];
  assign result_o = res_sel;
  assign tag_o    = tag_q[D-1];
`endif

endmodule
